mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit directly downstream of the EX/MEM pipeline register.
- Takes the registered ALU result (address), store data, transfer size and control bits. Drives a 64-bit data-memory port with a req/ready handshake.
- Aligns and zero-extends load data, and produces registered write-back outputs for the MEM/WB boundary.
- Stalls the pipeline while a memory access is outstanding, and aborts accesses that are misaligned or time out.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before abort with bus_err (must be ≥1)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
valid_mem  input  1  instruction in MEM stage is valid
alu_result_mem  input  64  byte address for mem ops; pass-through result otherwise
Db_mem  input  64  store data, right-justified
xfer_size_mem  input  4  bytes to transfer; legal 1,2,4,8
MemtoReg_mem  input  1  load
MemWrite_mem  input  1  store
RegWrite_mem  input  1  writes Rd
Rd_mem  input  5  destination register
dmem_req  output  1  memory request
dmem_we  output  1  1=write
dmem_addr  output  64  doubleword-aligned address (addr[2:0]=0)
dmem_wdata  output  64  lane-replicated store data
dmem_be  output  8  byte enables
dmem_ready  input  1  request accepted/completed this cycle
dmem_rdata  input  64  read doubleword, valid when dmem_ready
stall  output  1  hold EX/MEM and earlier stages
wb_valid  output  1  registered: result presented to WB
wb_data  output  64  registered load data or ALU result
wb_Rd  output  5  registered Rd
wb_RegWrite  output  1  registered write enable
misalign_err  output  1  registered 1-cycle pulse
bus_err  output  1  registered 1-cycle pulse

Behaviour:
- Reset (async): state=IDLE; all wb_*, misalign_err, bus_err = 0; wait counter = 0.
- Mem op = valid_mem & (MemtoReg_mem | MemWrite_mem). If both are set, the op is a load.
- Legal = xfer_size ∈ {1,2,4,8} and address is a multiple of the size.
- Lane offset = addr[2:0].
  - dmem_be = ((1<<size)-1) << offset.
  - dmem_wdata = Db_mem[8*size-1:0] replicated across all lanes.
- Load data = dmem_rdata >> (8*offset), masked to size and zero-extended to 64.

IDLE:
- Non-mem valid op: next edge loads wb_valid=1, wb_data=alu_result_mem, wb_Rd, wb_RegWrite. stall=0.
- valid_mem=0: wb_valid=0 and wb_RegWrite=0 next cycle.
- Illegal mem op: no dmem_req; misalign_err=1 next cycle; wb_valid=1 with wb_RegWrite=0; stall=0.
- Legal mem op: dmem_req=1 combinationally this cycle; request fields are captured into holding registers.
  - If dmem_ready=1 the same cycle (zero-wait): the op completes at this edge with stall=0.
  - Otherwise go to WAIT with stall=1.
- Completion: wb_valid=1, wb_Rd and wb_RegWrite from the op (stores force wb_RegWrite=0), wb_data = load data (loads) or alu_result_mem (stores).

WAIT:
- dmem_req=1; all dmem_* outputs are driven from the holding registers and are stable until ready.
- stall=1 except in the cycle dmem_ready=1.
- wb_valid=0 each cycle in WAIT.
- dmem_ready=1: the op completes at the edge; return to IDLE; counter cleared.
- Counter reaches TIMEOUT_CYCLES without ready: drop dmem_req; bus_err=1 next cycle; wb_valid=1, wb_RegWrite=0; return to IDLE.
- valid_mem and other inputs are ignored in WAIT, because upstream is held by stall.

Other rules:
- Asserting reset mid-WAIT drops dmem_req immediately and discards the op.
- misalign_err and bus_err are never asserted in the same cycle.
- Latency: non-mem ops 1 cycle; mem ops 1 + wait cycles.

Test Plan:
- Non-mem op: valid_mem=1, RegWrite=1, Rd=3, alu_result=0x1234 -> next cycle wb_valid=1, wb_data=0x1234, wb_Rd=3, stall=0.
- LDUR 8B zero-wait: addr=0x100, dmem_rdata=0xDEADBEEF_CAFEF00D, ready same cycle -> dmem_addr=0x100, be=0xFF, stall=0, wb_data=0xDEADBEEF_CAFEF00D.
- STURB with 3 wait cycles: addr=0x205, size=1, Db=0xAB -> dmem_addr=0x200, be=0x20, wdata=0xABAB…AB, we=1. stall=1 for 3 cycles, fields stable throughout. Then wb_valid=1, wb_RegWrite=0.
- LDURH: addr=0x106, size=2, rdata=0x1122_3344_5566_7788 -> wb_data=0x0000_0000_0000_1122.
- Misaligned/illegal: addr=0x103, size=4 -> no dmem_req, misalign_err pulse, wb_RegWrite=0. Same response for size=3.
- Timeout and reset: TIMEOUT_CYCLES=4, ready held 0 -> bus_err pulse after 4 WAIT cycles, stall then deasserts. Separately, reset asserted in WAIT -> dmem_req=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues aligned doubleword accesses with byte enables,
// holds the request stable while waiting, and registers the MEM/WB results.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_mem,
    input  logic [63:0] alu_result_mem,
    input  logic [63:0] Db_mem,
    input  logic [3:0]  xfer_size_mem,
    input  logic        MemtoReg_mem,
    input  logic        MemWrite_mem,
    input  logic        RegWrite_mem,
    input  logic [4:0]  Rd_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_Rd,
    output logic        wb_RegWrite,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dbg_state
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    function automatic logic [7:0] lane_be(input logic [3:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            4'd1:    m = 8'h01;
            4'd2:    m = 8'h03;
            4'd4:    m = 8'h0F;
            4'd8:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

    function automatic logic [63:0] lane_wdata(input logic [3:0] size, input logic [63:0] d);
        logic [63:0] r;
        case (size)
            4'd1:    r = {8{d[7:0]}};
            4'd2:    r = {4{d[15:0]}};
            4'd4:    r = {2{d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] load_align(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [3:0] size);
        logic [63:0] s;
        logic [63:0] r;
        s = rdata >> {off, 3'b000};
        case (size)
            4'd1:    r = {56'd0, s[7:0]};
            4'd2:    r = {48'd0, s[15:0]};
            4'd4:    r = {32'd0, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [7:0]    r_be;
    logic [3:0]    r_size;
    logic          r_load;
    logic [4:0]    r_rd;
    logic          r_regwrite;

    logic        w_in_wait;
    logic        w_mem_op;
    logic        w_size_ok;
    logic [2:0]  w_size_m1;
    logic        w_legal;
    logic        w_issue;
    logic [2:0]  w_cur_off;
    logic [3:0]  w_cur_size;
    logic [63:0] w_ld_data;

    assign w_in_wait  = (r_state == S_WAIT);
    assign w_mem_op   = valid_mem & (MemtoReg_mem | MemWrite_mem);
    assign w_size_ok  = (xfer_size_mem == 4'd1) | (xfer_size_mem == 4'd2) |
                        (xfer_size_mem == 4'd4) | (xfer_size_mem == 4'd8);
    // size-1 on the low 3 bits gives the alignment mask (size 8 wraps to 3'b111)
    assign w_size_m1  = xfer_size_mem[2:0] - 3'd1;
    assign w_legal    = w_size_ok & ((alu_result_mem[2:0] & w_size_m1) == 3'd0);
    assign w_issue    = !w_in_wait & w_mem_op & w_legal;
    assign w_cur_off  = w_in_wait ? r_addr[2:0] : alu_result_mem[2:0];
    assign w_cur_size = w_in_wait ? r_size : xfer_size_mem;
    assign w_ld_data  = load_align(dmem_rdata, w_cur_off, w_cur_size);
    assign dbg_state  = w_in_wait;

    // Reset gates the port so a held request disappears the instant reset rises.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 64'd0;
        dmem_wdata = 64'd0;
        dmem_be    = 8'd0;
        stall      = 1'b0;
        if (!reset) begin
            if (w_in_wait) begin
                dmem_req   = 1'b1;
                dmem_we    = !r_load;
                dmem_addr  = {r_addr[63:3], 3'b000};
                dmem_wdata = r_wdata;
                dmem_be    = r_be;
                stall      = !dmem_ready;
            end else if (w_issue) begin
                dmem_req   = 1'b1;
                dmem_we    = !MemtoReg_mem;
                dmem_addr  = {alu_result_mem[63:3], 3'b000};
                dmem_wdata = lane_wdata(xfer_size_mem, Db_mem);
                dmem_be    = lane_be(xfer_size_mem, alu_result_mem[2:0]);
                stall      = !dmem_ready;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_be         <= 8'd0;
            r_size       <= 4'd0;
            r_load       <= 1'b0;
            r_rd         <= 5'd0;
            r_regwrite   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= 64'd0;
            wb_Rd        <= 5'd0;
            wb_RegWrite  <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            if (!w_in_wait) begin
                if (!valid_mem) begin
                    wb_valid    <= 1'b0;
                    wb_RegWrite <= 1'b0;
                end else if (!w_mem_op) begin
                    wb_valid    <= 1'b1;
                    wb_data     <= alu_result_mem;
                    wb_Rd       <= Rd_mem;
                    wb_RegWrite <= RegWrite_mem;
                end else if (!w_legal) begin
                    wb_valid     <= 1'b1;
                    wb_data      <= alu_result_mem;
                    wb_Rd        <= Rd_mem;
                    wb_RegWrite  <= 1'b0;
                    misalign_err <= 1'b1;
                end else begin
                    r_addr     <= alu_result_mem;
                    r_wdata    <= lane_wdata(xfer_size_mem, Db_mem);
                    r_be       <= lane_be(xfer_size_mem, alu_result_mem[2:0]);
                    r_size     <= xfer_size_mem;
                    r_load     <= MemtoReg_mem;
                    r_rd       <= Rd_mem;
                    r_regwrite <= RegWrite_mem;
                    r_cnt      <= '0;
                    if (dmem_ready) begin
                        wb_valid    <= 1'b1;
                        wb_data     <= MemtoReg_mem ? w_ld_data : alu_result_mem;
                        wb_Rd       <= Rd_mem;
                        wb_RegWrite <= RegWrite_mem & MemtoReg_mem;
                    end else begin
                        r_state     <= S_WAIT;
                        wb_valid    <= 1'b0;
                        wb_RegWrite <= 1'b0;
                    end
                end
            end else begin
                if (dmem_ready) begin
                    wb_valid    <= 1'b1;
                    wb_data     <= r_load ? w_ld_data : r_addr;
                    wb_Rd       <= r_rd;
                    wb_RegWrite <= r_regwrite & r_load;
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    bus_err     <= 1'b1;
                    wb_valid    <= 1'b1;
                    wb_data     <= r_addr;
                    wb_Rd       <= r_rd;
                    wb_RegWrite <= 1'b0;
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                end else begin
                    r_cnt       <= r_cnt + CW'(1);
                    wb_valid    <= 1'b0;
                    wb_RegWrite <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases from the test plan, then random ops
// checked against an arithmetic model of lane enables, replication and load alignment.
module tb_mem_stage_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_mem;
    logic [63:0] alu_result_mem;
    logic [63:0] Db_mem;
    logic [3:0]  xfer_size_mem;
    logic        MemtoReg_mem;
    logic        MemWrite_mem;
    logic        RegWrite_mem;
    logic [4:0]  Rd_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_Rd;
    logic        wb_RegWrite;
    logic        misalign_err;
    logic        bus_err;
    logic        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .valid_mem(valid_mem), .alu_result_mem(alu_result_mem),
        .Db_mem(Db_mem), .xfer_size_mem(xfer_size_mem), .MemtoReg_mem(MemtoReg_mem),
        .MemWrite_mem(MemWrite_mem), .RegWrite_mem(RegWrite_mem), .Rd_mem(Rd_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_Rd(wb_Rd), .wb_RegWrite(wb_RegWrite), .misalign_err(misalign_err),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    task automatic check1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic checkv(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic bit m_legal(input logic [63:0] addr, input logic [3:0] size);
        if (!(size == 1 || size == 2 || size == 4 || size == 8)) return 1'b0;
        return (addr % 64'(size)) == 64'd0;
    endfunction

    function automatic logic [7:0] m_be(input logic [63:0] addr, input logic [3:0] size);
        logic [15:0] v;
        v = ((16'd1 << size) - 16'd1) << addr[2:0];
        return v[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] db, input logic [3:0] size);
        logic [63:0] r;
        r = 64'd0;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = db[8*(b % int'(size)) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [3:0] size);
        logic [63:0] v;
        v = rdata >> (8 * int'(addr[2:0]));
        if (size < 8) v = v & ((64'd1 << (8 * int'(size))) - 64'd1);
        return v;
    endfunction

    // One instruction through MEM; the model decides bubble / non-mem / illegal / access.
    task automatic run_op(input logic v, input logic ld, input logic st, input logic rw,
                          input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] db,
                          input logic [3:0] size, input int nwait, input logic [63:0] rdata);
        bit memop;
        bit legal;
        logic [63:0] ewd;
        logic [7:0] ebe;
        memop = v && (ld || st);
        legal = m_legal(addr, size);
        @(negedge clk);
        valid_mem = v; alu_result_mem = addr; Db_mem = db; xfer_size_mem = size;
        MemtoReg_mem = ld; MemWrite_mem = st; RegWrite_mem = rw; Rd_mem = rd;
        dmem_ready = memop && legal && (nwait == 0);
        dmem_rdata = dmem_ready ? rdata : rnd64();
        #1;
        if (!(memop && legal)) begin
            check1("req_noissue", dmem_req, 1'b0);
            check1("stall_noissue", stall, 1'b0);
            @(negedge clk);
            valid_mem = 1'b0;
            #1;
            if (!v) begin
                check1("bubble_wb_valid", wb_valid, 1'b0);
                check1("bubble_wb_regwrite", wb_RegWrite, 1'b0);
            end else if (!memop) begin
                check1("alu_wb_valid", wb_valid, 1'b1);
                checkv("alu_wb_data", wb_data, addr);
                checkv("alu_wb_rd", 64'(wb_Rd), 64'(rd));
                check1("alu_wb_regwrite", wb_RegWrite, rw);
                check1("alu_misalign", misalign_err, 1'b0);
            end else begin
                check1("ill_misalign", misalign_err, 1'b1);
                check1("ill_wb_valid", wb_valid, 1'b1);
                check1("ill_wb_regwrite", wb_RegWrite, 1'b0);
                check1("ill_bus_err", bus_err, 1'b0);
            end
        end else begin
            ebe = m_be(addr, size);
            ewd = m_wdata(db, size);
            exp_q.push_back(ld ? m_load(rdata, addr, size) : addr);
            check1("issue_req", dmem_req, 1'b1);
            check1("issue_we", dmem_we, !ld);
            checkv("issue_addr", dmem_addr, addr & ~64'h7);
            checkv("issue_be", 64'(dmem_be), 64'(ebe));
            checkv("issue_wdata", dmem_wdata, ewd);
            check1("issue_stall", stall, nwait != 0);
            for (int k = 1; k <= nwait; k++) begin
                @(negedge clk);
                valid_mem = 1'($urandom_range(0, 1));
                alu_result_mem = rnd64(); Db_mem = rnd64();
                xfer_size_mem = 4'($urandom_range(0, 15));
                dmem_ready = (k == nwait);
                dmem_rdata = dmem_ready ? rdata : rnd64();
                #1;
                check1("wait_req", dmem_req, 1'b1);
                check1("wait_we", dmem_we, !ld);
                checkv("wait_addr", dmem_addr, addr & ~64'h7);
                checkv("wait_be", 64'(dmem_be), 64'(ebe));
                checkv("wait_wdata", dmem_wdata, ewd);
                check1("wait_stall", stall, k != nwait);
                check1("wait_wb_valid", wb_valid, 1'b0);
            end
            @(negedge clk);
            valid_mem = 1'b0; dmem_ready = 1'b0;
            #1;
            check1("done_wb_valid", wb_valid, 1'b1);
            checkv("done_wb_data", wb_data, exp_q.pop_front());
            checkv("done_wb_rd", 64'(wb_Rd), 64'(rd));
            check1("done_wb_regwrite", wb_RegWrite, rw && ld);
            check1("done_misalign", misalign_err, 1'b0);
            check1("done_bus_err", bus_err, 1'b0);
            check1("done_state_idle", dbg_state, 1'b0);
            check1("done_req", dmem_req, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [3:0]  sz;
        int          kind;
        int          sel;
        reset = 1'b1; valid_mem = 1'b0; alu_result_mem = 64'd0; Db_mem = 64'd0;
        xfer_size_mem = 4'd0; MemtoReg_mem = 1'b0; MemWrite_mem = 1'b0;
        RegWrite_mem = 1'b0; Rd_mem = 5'd0; dmem_ready = 1'b0; dmem_rdata = 64'd0;
        repeat (2) @(negedge clk);
        #1;
        check1("rst_wb_valid", wb_valid, 1'b0);
        checkv("rst_wb_data", wb_data, 64'd0);
        checkv("rst_wb_rd", 64'(wb_Rd), 64'd0);
        check1("rst_wb_regwrite", wb_RegWrite, 1'b0);
        check1("rst_misalign", misalign_err, 1'b0);
        check1("rst_bus_err", bus_err, 1'b0);
        check1("rst_req", dmem_req, 1'b0);
        check1("rst_stall", stall, 1'b0);
        check1("rst_state", dbg_state, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        run_op(1, 0, 0, 1, 5'd3, 64'h1234, 64'd0, 4'd8, 0, 64'd0);
        run_op(1, 1, 0, 1, 5'd5, 64'h100, 64'd0, 4'd8, 0, 64'hDEADBEEF_CAFEF00D);
        run_op(1, 0, 1, 1, 5'd7, 64'h205, 64'hAB, 4'd1, 3, 64'd0);
        run_op(1, 1, 0, 1, 5'd9, 64'h106, 64'd0, 4'd2, 1, 64'h1122_3344_5566_7788);
        run_op(1, 1, 0, 1, 5'd2, 64'h103, 64'd0, 4'd4, 0, 64'd0);
        run_op(1, 0, 1, 1, 5'd2, 64'h100, 64'h77, 4'd3, 0, 64'd0);
        run_op(1, 1, 1, 1, 5'd4, 64'h10C, 64'h55, 4'd4, 2, 64'hA1B2C3D4_E5F60718);
        run_op(1, 0, 1, 0, 5'd1, 64'h3F0, 64'h0102030405060708, 4'd8, TO, 64'd0);
        run_op(0, 1, 0, 1, 5'd6, 64'h40, 64'd0, 4'd8, 0, 64'd0);

        // Timeout: no ready for TO wait cycles.
        @(negedge clk);
        valid_mem = 1'b1; alu_result_mem = 64'h308; xfer_size_mem = 4'd8;
        MemtoReg_mem = 1'b1; MemWrite_mem = 1'b0; RegWrite_mem = 1'b1; Rd_mem = 5'd12;
        dmem_ready = 1'b0;
        #1;
        check1("to_issue_req", dmem_req, 1'b1);
        check1("to_issue_stall", stall, 1'b1);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            #1;
            check1("to_wait_req", dmem_req, 1'b1);
            check1("to_wait_stall", stall, 1'b1);
            check1("to_wait_bus_err", bus_err, 1'b0);
        end
        @(negedge clk);
        valid_mem = 1'b0;
        #1;
        check1("to_bus_err", bus_err, 1'b1);
        check1("to_wb_valid", wb_valid, 1'b1);
        check1("to_wb_regwrite", wb_RegWrite, 1'b0);
        check1("to_misalign", misalign_err, 1'b0);
        check1("to_req_dropped", dmem_req, 1'b0);
        check1("to_stall_released", stall, 1'b0);
        @(negedge clk);
        #1;
        check1("to_bus_err_pulse", bus_err, 1'b0);

        // Reset while waiting: port and results clear at once, op discarded.
        @(negedge clk);
        valid_mem = 1'b1; alu_result_mem = 64'h510; xfer_size_mem = 4'd4;
        MemtoReg_mem = 1'b0; MemWrite_mem = 1'b1; Db_mem = 64'h99;
        #1;
        @(negedge clk);
        #1;
        check1("rw_req_before", dmem_req, 1'b1);
        reset = 1'b1;
        #1;
        check1("rw_req", dmem_req, 1'b0);
        check1("rw_stall", stall, 1'b0);
        checkv("rw_be", 64'(dmem_be), 64'd0);
        checkv("rw_addr", dmem_addr, 64'd0);
        check1("rw_wb_valid", wb_valid, 1'b0);
        checkv("rw_wb_data", wb_data, 64'd0);
        check1("rw_state", dbg_state, 1'b0);
        @(negedge clk);
        valid_mem = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            sel = $urandom_range(0, 3);
            sz = 4'd1 << sel;
            a = rnd64();
            if (kind == 0) begin
                run_op(0, 1, 0, 1, 5'($urandom), a, rnd64(), sz, 0, 64'd0);
            end else if (kind <= 2) begin
                run_op(1, 0, 0, 1'($urandom_range(0, 1)), 5'($urandom), a, rnd64(), sz, 0, 64'd0);
            end else if (kind == 3) begin
                do begin
                    a = rnd64();
                    sz = 4'($urandom_range(0, 15));
                end while (m_legal(a, sz));
                run_op(1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 5'($urandom), a, rnd64(), sz, 0, 64'd0);
            end else begin
                sel = $urandom_range(1, 3);
                a = a & ~(64'(sz) - 64'd1);
                run_op(1, sel[1], sel[0], 1'($urandom_range(0, 1)), 5'($urandom), a, rnd64(), sz,
                       $urandom_range(0, TO), rnd64());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
